writeback_stage: RTL and testbench
==================================

# writeback_stage

Parametrised write-back stage of the pipelined MIPS core, sitting after MEM and driving the register-file write port and the forwarding unit. It owns the MEM/WB pipeline register and performs load-data extraction (byte/half/word, signed/unsigned). It selects the write-back source (ALU, memory, link address) and suppresses illegal writes. It also keeps a retired-instruction counter for the debug unit. Halt freezes the stage; flush kills the entry being captured.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; 32 is the only legal value (checked by elaboration assertion)
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, retired-counter width
- ZERO_REG_PROTECT, 1, when 1 writes to register 0 are suppressed

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous active-high reset
- i_halt  in  1  freeze latch and counter
- i_flush  in  1  capture a bubble instead of the incoming entry
- i_valid  in  1  MEM stage holds a real instruction
- i_reg_write  in  1  instruction writes a register
- i_wb_sel  in  2  00 ALU, 01 memory, 10 link, 11 treated as ALU
- i_mem_size  in  2  00 byte, 01 half, 10/11 word
- i_mem_unsigned  in  1  zero-extend (1) or sign-extend (0) loads
- i_addr_lsb  in  2  low address bits of the load
- i_alu_result  in  DATA_WIDTH  ALU result
- i_mem_data  in  DATA_WIDTH  raw aligned word from data memory
- i_link_addr  in  DATA_WIDTH  return address (PC+8)
- i_reg_dest  in  REG_ADDR_WIDTH  destination register
- o_rf_we  out  1  register-file write enable
- o_rf_addr  out  REG_ADDR_WIDTH  write address
- o_rf_data  out  DATA_WIDTH  write data
- o_misaligned  out  1  latched load is misaligned
- o_retired  out  CNT_WIDTH  count of valid instructions captured

## Operation
- MEM/WB latch holds: valid, reg_write, wb_sel, mem_size, mem_unsigned, addr_lsb, alu_result, mem_data, link_addr, reg_dest.
- On each rising edge:
  - i_halt=1: latch and counter hold; i_flush is ignored.
  - Else, i_flush=1: latch loads with valid=0; other fields are don't-care; the counter holds.
  - Else: latch loads all inputs, and the counter increments by 1 iff i_valid=1. The counter wraps modulo 2^CNT_WIDTH.
- Load extraction uses latched values:
  - Byte: lane addr_lsb (bits 8*lsb+7:8*lsb).
  - Half: lane addr_lsb[1] (bits 16*lsb[1]+15:16*lsb[1]).
  - Word: whole word.
  - Sign- or zero-extend to DATA_WIDTH per mem_unsigned.
- Misaligned: half with addr_lsb[0]=1, or word with addr_lsb≠00. Flag is raised only when wb_sel=01 and valid=1.
- Data select: ALU → alu_result, memory → extracted load, link → link_addr.
- o_rf_we = valid & reg_write & ~misaligned & ~(ZERO_REG_PROTECT & reg_dest==0).
- o_rf_addr = latched reg_dest. o_rf_data = selected data, driven regardless of o_rf_we.
- The register file writes on the next rising edge; forwarding consumes o_rf_* combinationally.

## Timing
- Latency: inputs sampled at edge N appear on o_rf_* after edge N and persist until edge N+1 (or longer under halt).
- Reset (asynchronous, immediate): latch cleared to all-zero (valid=0), o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_misaligned=0, o_retired=0.
- Reset released mid-halt: stage starts empty and frozen until i_halt falls.
- Halt asserted with a valid entry latched: o_rf_we stays asserted with the same address and data for every halted cycle; the register-file write is idempotent.
- Flush and halt together: halt wins.
- Counter at all-ones plus a valid capture: counter becomes 0.

## Structure
- Shared package core_pkg:
  - wb_sel encodings: WB_SEL_ALU, WB_SEL_MEM, WB_SEL_LINK.
  - mem_size encodings: MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W.
- Sub-module load_align: purely combinational. Inputs mem_data, size, unsigned, lsb. Outputs extended data and the misaligned flag. Reused by the debug memory reader.
- Top-level contains the latch, counter, select mux and write-enable logic.

## Test plan
- Reset mid-run: assert i_reset between edges → all outputs 0 immediately; o_retired=0 after release.
- ALU write: valid, reg_write, wb_sel=00, alu=0x0000_1234, dest=5 → next cycle o_rf_we=1, addr=5, data=0x0000_1234; o_retired=1.
- Loads with mem_data=0x80FF_7F01:
  - LB lsb=3 → 0xFFFF_FF80.
  - LBU lsb=3 → 0x0000_0080.
  - LH lsb=2 → 0xFFFF_80FF.
  - LHU lsb=0 → 0x0000_7F01.
  - LH lsb=1 → o_misaligned=1, o_rf_we=0.
- Zero-register and link writes:
  - dest=0 with ZERO_REG_PROTECT=1 → o_rf_we=0.
  - wb_sel=10, link=0x0000_0048, dest=31 → data 0x0000_0048, o_rf_we=1.
- Halt, then flush:
  - Hold i_halt for 3 cycles while inputs change → o_rf_* and o_retired constant.
  - i_flush alone with i_valid=1 → o_rf_we=0; counter unchanged.
- Counter wrap: CNT_WIDTH=4, 17 valid captures → o_retired=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core encodings: write-back source select, load size, and the MEM/WB control payload.
package core_pkg;

  localparam int unsigned WB_SEL_WIDTH   = 2;
  localparam int unsigned MEM_SIZE_WIDTH = 2;
  localparam int unsigned LSB_WIDTH      = 2;

  typedef enum logic [WB_SEL_WIDTH-1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10
  } wb_sel_e;

  typedef enum logic [MEM_SIZE_WIDTH-1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10
  } mem_size_e;

  // Control half of the MEM/WB pipeline register.
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [WB_SEL_WIDTH-1:0]   wb_sel;
    logic [MEM_SIZE_WIDTH-1:0] mem_size;
    logic                      mem_unsigned;
    logic [LSB_WIDTH-1:0]      addr_lsb;
  } wb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction: picks the byte/half lane, extends it, flags misalignment.
module load_align
  import core_pkg::*;
(
  input  logic [31:0]               i_mem_data,
  input  logic [MEM_SIZE_WIDTH-1:0] i_size,
  input  logic                      i_unsigned,
  input  logic [LSB_WIDTH-1:0]      i_lsb,
  output logic [31:0]               o_data,
  output logic                      o_misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = i_mem_data[{i_lsb, 3'b000} +: 8];
  assign half_lane = i_mem_data[{i_lsb[1], 4'b0000} +: 16];

  always_comb begin
    o_data       = i_mem_data;
    o_misaligned = 1'b0;
    case (i_size)
      MEM_SIZE_B: begin
        o_data = i_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      MEM_SIZE_H: begin
        o_data       = i_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        o_misaligned = i_lsb[0];
      end
      default: begin
        // Encoding 11 behaves as a word access.
        o_data       = i_mem_data;
        o_misaligned = (i_lsb != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MIPS write-back stage: MEM/WB register, load extraction, source select, write gating, retire counter.
module writeback_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter bit          ZERO_REG_PROTECT = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_halt,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic                      i_reg_write,
  input  logic [WB_SEL_WIDTH-1:0]   i_wb_sel,
  input  logic [MEM_SIZE_WIDTH-1:0] i_mem_size,
  input  logic                      i_mem_unsigned,
  input  logic [LSB_WIDTH-1:0]      i_addr_lsb,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [DATA_WIDTH-1:0]     i_link_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_reg_dest,
  output logic                      o_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0]     o_rf_data,
  output logic                      o_misaligned,
  output logic [CNT_WIDTH-1:0]      o_retired
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("writeback_stage: DATA_WIDTH must be 32");
  end

  wb_ctrl_t                  ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]     alu_q, alu_d;
  logic [DATA_WIDTH-1:0]     mem_q, mem_d;
  logic [DATA_WIDTH-1:0]     link_q, link_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_misaligned;
  logic                  zero_dest;

  // Next-state: halt freezes everything, flush captures a bubble, otherwise capture inputs.
  always_comb begin
    ctrl_d = ctrl_q;
    alu_d  = alu_q;
    mem_d  = mem_q;
    link_d = link_q;
    dest_d = dest_q;
    cnt_d  = cnt_q;
    if (!i_halt) begin
      ctrl_d.valid        = i_valid & ~i_flush;
      ctrl_d.reg_write    = i_reg_write;
      ctrl_d.wb_sel       = i_wb_sel;
      ctrl_d.mem_size     = i_mem_size;
      ctrl_d.mem_unsigned = i_mem_unsigned;
      ctrl_d.addr_lsb     = i_addr_lsb;
      alu_d               = i_alu_result;
      mem_d               = i_mem_data;
      link_d              = i_link_addr;
      dest_d              = i_reg_dest;
      if (!i_flush) begin
        cnt_d = cnt_q + CNT_WIDTH'(i_valid);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      link_q <= '0;
      dest_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      mem_q  <= mem_d;
      link_q <= link_d;
      dest_q <= dest_d;
      cnt_q  <= cnt_d;
    end
  end

  load_align u_load_align (
    .i_mem_data   (mem_q),
    .i_size       (ctrl_q.mem_size),
    .i_unsigned   (ctrl_q.mem_unsigned),
    .i_lsb        (ctrl_q.addr_lsb),
    .o_data       (load_data),
    .o_misaligned (load_misaligned)
  );

  // Outputs derive from the latch only, so forwarding sees them right after the capture edge.
  always_comb begin
    o_misaligned = ctrl_q.valid & (ctrl_q.wb_sel == WB_SEL_MEM) & load_misaligned;
    zero_dest    = ZERO_REG_PROTECT & (dest_q == '0);
    o_rf_we      = ctrl_q.valid & ctrl_q.reg_write & ~o_misaligned & ~zero_dest;
    o_rf_addr    = dest_q;
    case (ctrl_q.wb_sel)
      WB_SEL_MEM:  o_rf_data = load_data;
      WB_SEL_LINK: o_rf_data = link_q;
      default:     o_rf_data = alu_q;
    endcase
    o_retired = cnt_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage (default build plus a 4-bit counter build).
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, flush, valid, rw, uns;
  logic [1:0]  sel, size, lsb;
  logic [31:0] alu, mem, link;
  logic [4:0]  dest;

  logic        we, mis, we4, mis4;
  logic [4:0]  addr, addr4;
  logic [31:0] data, data4, ret;
  logic [3:0]  ret4;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        mis;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] ret;
    logic [3:0]  ret4;
  } exp_t;

  exp_t exp_q[$];

  // Architectural view of the instruction sitting in write-back.
  logic        m_valid, m_rw, m_uns;
  logic [1:0]  m_sel, m_size, m_lsb;
  logic [31:0] m_alu, m_mem, m_link, m_cnt;
  logic [4:0]  m_dest;
  logic [3:0]  m_cnt4;

  always #5 clk = ~clk;

  writeback_stage dut (
    .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_flush(flush), .i_valid(valid),
    .i_reg_write(rw), .i_wb_sel(sel), .i_mem_size(size), .i_mem_unsigned(uns),
    .i_addr_lsb(lsb), .i_alu_result(alu), .i_mem_data(mem), .i_link_addr(link),
    .i_reg_dest(dest), .o_rf_we(we), .o_rf_addr(addr), .o_rf_data(data),
    .o_misaligned(mis), .o_retired(ret)
  );

  writeback_stage #(.CNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_flush(flush), .i_valid(valid),
    .i_reg_write(rw), .i_wb_sel(sel), .i_mem_size(size), .i_mem_unsigned(uns),
    .i_addr_lsb(lsb), .i_alu_result(alu), .i_mem_data(mem), .i_link_addr(link),
    .i_reg_dest(dest), .o_rf_we(we4), .o_rf_addr(addr4), .o_rf_data(data4),
    .o_misaligned(mis4), .o_retired(ret4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    logic [31:0] v;
    logic        misal;
    case (m_size)
      2'd0: begin
        v = (m_mem >> (8 * m_lsb)) & 32'hFF;
        if (!m_uns && v[7]) v = v | 32'hFFFF_FF00;
        misal = 1'b0;
      end
      2'd1: begin
        v = (m_mem >> (16 * (m_lsb / 2))) & 32'hFFFF;
        if (!m_uns && v[15]) v = v | 32'hFFFF_0000;
        misal = (m_lsb % 2) == 1;
      end
      default: begin
        v     = m_mem;
        misal = m_lsb != 0;
      end
    endcase
    e.valid = m_valid;
    e.mis   = m_valid && m_sel == 2'd1 && misal;
    e.we    = m_valid && m_rw && !e.mis && m_dest != 0;
    e.addr  = m_dest;
    e.data  = (m_sel == 2'd1) ? v : (m_sel == 2'd2) ? m_link : m_alu;
    e.ret   = m_cnt;
    e.ret4  = m_cnt4;
    return e;
  endfunction

  // Reference model: update on each edge and post the expected visible state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_rw = 0; m_uns = 0; m_sel = 0; m_size = 0; m_lsb = 0;
      m_alu = 0; m_mem = 0; m_link = 0; m_dest = 0; m_cnt = 0; m_cnt4 = 0;
      exp_q.delete();
    end else begin
      if (!halt) begin
        if (flush) begin
          m_valid = 0;
        end else begin
          m_valid = valid; m_rw = rw; m_uns = uns; m_sel = sel; m_size = size;
          m_lsb = lsb; m_alu = alu; m_mem = mem; m_link = link; m_dest = dest;
          if (valid) begin
            m_cnt  = m_cnt + 1;
            m_cnt4 = m_cnt4 + 1;
          end
        end
      end
      exp_q.push_back(model_out());
    end
  end

  // Monitor: compare the presented outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_we", 32'(we), 32'(e.we));
      chk("misaligned", 32'(mis), 32'(e.mis));
      chk("retired", ret, e.ret);
      chk("retired4", 32'(ret4), 32'(e.ret4));
      chk("rf_we4", 32'(we4), 32'(e.we));
      chk("misaligned4", 32'(mis4), 32'(e.mis));
      if (e.valid) begin
        chk("rf_addr", 32'(addr), 32'(e.addr));
        chk("rf_data", data, e.data);
        chk("rf_data4", data4, e.data);
        chk("rf_addr4", 32'(addr4), 32'(e.addr));
      end
    end
  end

  task automatic op(input logic v, input logic w, input logic [1:0] s, input logic [1:0] sz,
                    input logic u, input logic [1:0] l, input logic [31:0] a,
                    input logic [31:0] m, input logic [31:0] k, input logic [4:0] d);
    valid = v; rw = w; sel = s; size = sz; uns = u; lsb = l;
    alu = a; mem = m; link = k; dest = d;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("reset_we", 32'(we), 32'h0);
    chk("reset_addr", 32'(addr), 32'h0);
    chk("reset_data", data, 32'h0);
    chk("reset_mis", 32'(mis), 32'h0);
    chk("reset_retired", ret, 32'h0);
    chk("reset_retired4", 32'(ret4), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] LD = 32'h80FF_7F01;
    rst = 1; halt = 0; flush = 0;
    valid = 0; rw = 0; sel = 0; size = 0; uns = 0; lsb = 0;
    alu = 0; mem = 0; link = 0; dest = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 0;

    op(1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h0000_1234, 0, 0, 5'd5);
    chk("alu_we", 32'(we), 32'h1);
    chk("alu_addr", 32'(addr), 32'd5);
    chk("alu_data", data, 32'h0000_1234);
    chk("alu_retired", ret, 32'd1);
    op(1, 1, 2'd1, 2'd0, 0, 2'd3, 0, LD, 0, 5'd6);
    chk("lb", data, 32'hFFFF_FF80);
    op(1, 1, 2'd1, 2'd0, 1, 2'd3, 0, LD, 0, 5'd6);
    chk("lbu", data, 32'h0000_0080);
    op(1, 1, 2'd1, 2'd1, 0, 2'd2, 0, LD, 0, 5'd7);
    chk("lh", data, 32'hFFFF_80FF);
    op(1, 1, 2'd1, 2'd1, 1, 2'd0, 0, LD, 0, 5'd7);
    chk("lhu", data, 32'h0000_7F01);
    op(1, 1, 2'd1, 2'd1, 0, 2'd1, 0, LD, 0, 5'd8);
    chk("lh_mis_flag", 32'(mis), 32'h1);
    chk("lh_mis_we", 32'(we), 32'h0);
    op(1, 1, 2'd0, 2'd2, 0, 2'd0, 32'hDEAD_BEEF, 0, 0, 5'd0);
    chk("zero_reg_we", 32'(we), 32'h0);
    op(1, 1, 2'd2, 2'd2, 0, 2'd0, 32'h1111_1111, 0, 32'h0000_0048, 5'd31);
    chk("link_data", data, 32'h0000_0048);
    chk("link_we", 32'(we), 32'h1);

    halt = 1;
    for (int i = 0; i < 3; i++) begin
      op(1, 1, 2'd0, 2'd2, 0, 2'd0, $urandom, $urandom, $urandom, 5'(i + 1));
      chk("halt_we", 32'(we), 32'h1);
      chk("halt_addr", 32'(addr), 32'd31);
      chk("halt_data", data, 32'h0000_0048);
      chk("halt_retired", ret, 32'd8);
    end
    halt = 0; flush = 1;
    op(1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h5, 0, 0, 5'd9);
    chk("flush_we", 32'(we), 32'h0);
    chk("flush_retired", ret, 32'd8);
    flush = 0;

    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        rst = 1; #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 0;
      end
      halt  = ($urandom_range(7) == 0);
      flush = ($urandom_range(7) == 0);
      op($urandom_range(3) != 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
         2'($urandom_range(3)), 1'($urandom_range(1)), 2'($urandom_range(3)),
         $urandom, $urandom, $urandom,
         ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)));
    end
    halt = 0; flush = 0; valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
